uart_apb_ctrl: RTL and testbench

- Autonomous APB master that configures and services one CoreUARTapb instance, so fabric logic needs no CPU or bus BFM.
- After reset it writes the UART control registers once, then polls the status register.
- It moves bytes between byte-stream valid/ready ports and the UART TX/RX data registers, using round-robin arbitration between TX and RX service.

---
 rtl/uart_apb_ctrl.sv | 169 ++++++++++++++++
 tb/tb_uart_apb_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_ctrl.sv
// Autonomous APB master for one CoreUARTapb: programs the baud/format registers once,
// then polls STATUS and moves bytes between the valid/ready streams and TX/RX data.
module uart_apb_ctrl #(
  parameter logic [12:0] BAUD_VALUE = 13'd26,
  parameter logic        PRG_BIT8   = 1'b1,
  parameter logic [1:0]  PRG_PARITY = 2'b00
) (
  input  logic       PCLK,
  input  logic       PRESET,
  output logic [4:0] PADDR,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [2:0] err_status,
  input  logic       err_clr,
  output logic       cfg_done
);

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;

  localparam logic [7:0] CTRL1_VAL = BAUD_VALUE[7:0];
  localparam logic [7:0] CTRL2_VAL = {BAUD_VALUE[12:8], PRG_PARITY[1], PRG_PARITY[0], PRG_BIT8};

  typedef enum logic [2:0] {CFG1, CFG2, POLL, TXWR, RXRD} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_ACCESS} phase_t;

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic [2:0] err_q, err_d;
  logic       cfg_done_q, cfg_done_d;
  logic       last_rx_q, last_rx_d;
  logic       tx_elig, rx_elig;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= CFG1;
      phase_q    <= PH_IDLE;
      tx_byte_q  <= 8'h00;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      err_q      <= 3'b000;
      cfg_done_q <= 1'b0;
      last_rx_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      tx_byte_q  <= tx_byte_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_q      <= err_d;
      cfg_done_q <= cfg_done_d;
      last_rx_q  <= last_rx_d;
    end
  end

  // Bus outputs decode from state and phase; PH_IDLE only exists right after reset,
  // which keeps every bus output low while PRESET is held.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    tx_byte_d  = tx_byte_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    err_d      = err_q;
    cfg_done_d = cfg_done_q;
    last_rx_d  = last_rx_q;
    tx_elig    = 1'b0;
    rx_elig    = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    PADDR      = 5'h00;
    PWDATA     = 8'h00;
    tx_ready   = 1'b0;

    if (err_clr) err_d = 3'b000;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (phase_q != PH_IDLE) begin
      PSEL    = 1'b1;
      PENABLE = (phase_q == PH_ACCESS);
      case (state_q)
        CFG1: begin
          PADDR  = ADDR_CTRL1;
          PWRITE = 1'b1;
          PWDATA = CTRL1_VAL;
        end
        CFG2: begin
          PADDR  = ADDR_CTRL2;
          PWRITE = 1'b1;
          PWDATA = CTRL2_VAL;
        end
        POLL: PADDR = ADDR_STATUS;
        TXWR: begin
          PADDR    = ADDR_TXDATA;
          PWRITE   = 1'b1;
          tx_ready = (phase_q == PH_SETUP);
          PWDATA   = (phase_q == PH_SETUP) ? tx_data : tx_byte_q;
        end
        RXRD: PADDR = ADDR_RXDATA;
        default: PADDR = 5'h00;
      endcase
    end

    case (phase_q)
      PH_IDLE: phase_d = PH_SETUP;
      PH_SETUP: begin
        phase_d = PH_ACCESS;
        if (state_q == TXWR) tx_byte_d = tx_data;
      end
      PH_ACCESS: begin
        if (PREADY) begin
          phase_d = PH_SETUP;
          case (state_q)
            CFG1: state_d = CFG2;
            CFG2: begin
              cfg_done_d = 1'b1;
              state_d    = POLL;
            end
            // New error bits are ORed after the clear so a coincident err_clr loses.
            POLL: begin
              err_d   = err_d | {PRDATA[4], PRDATA[3], PRDATA[2]};
              tx_elig = PRDATA[0] & tx_valid;
              rx_elig = PRDATA[1] & ~rx_valid_q;
              if (tx_elig && rx_elig) state_d = last_rx_q ? TXWR : RXRD;
              else if (tx_elig)       state_d = TXWR;
              else if (rx_elig)       state_d = RXRD;
              else                    state_d = POLL;
            end
            TXWR: begin
              last_rx_d = 1'b0;
              state_d   = POLL;
            end
            RXRD: begin
              rx_data_d  = PRDATA;
              rx_valid_d = 1'b1;
              last_rx_d  = 1'b1;
              state_d    = POLL;
            end
            default: state_d = CFG1;
          endcase
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign err_status = err_q;
  assign cfg_done   = cfg_done_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Bench for uart_apb_ctrl: a scripted APB slave feeds STATUS/RXDATA values while a
// monitor checks every bus transfer and received byte against queued expectations.
module tb_uart_apb_ctrl;

  localparam logic [4:0] A_TX = 5'h00;
  localparam logic [4:0] A_RX = 5'h04;
  localparam logic [4:0] A_C1 = 5'h08;
  localparam logic [4:0] A_C2 = 5'h0C;
  localparam logic [4:0] A_ST = 5'h10;

  typedef struct packed {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] data;
  } xfer_t;

  logic       PCLK;
  logic       PRESET;
  logic [4:0] PADDR;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA = 8'hFF;
  logic       PREADY = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] err_status;
  logic       err_clr;
  logic       cfg_done;

  xfer_t      exp_q[$];
  logic [7:0] status_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   wait_n = 0;
  int   wait_cur = 0;
  int   wcnt = 0;
  int   acc_cnt = 0;
  logic after_done = 1'b0;
  logic txr_prev = 1'b0;

  uart_apb_ctrl dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .err_status(err_status), .err_clr(err_clr), .cfg_done(cfg_done)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic failNow(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: got 0x%0h, required nothing pending", name, act);
  endtask

  task automatic sync();
    @(posedge PCLK);
    #2;
  endtask

  task automatic expXfer(input logic wr, input logic [4:0] addr, input logic [7:0] data);
    xfer_t x;
    x.wr   = wr;
    x.addr = addr;
    x.data = data;
    exp_q.push_back(x);
  endtask

  // One scripted STATUS value, answered by the next STATUS read the DUT makes.
  task automatic applyStimulus(input logic [7:0] status);
    status_q.push_back(status);
    expXfer(1'b0, A_ST, 8'h00);
  endtask

  task automatic expRxByte(input logic [7:0] b);
    expXfer(1'b0, A_RX, 8'h00);
    rx_q.push_back(b);
    exp_rx.push_back(b);
  endtask

  task automatic waitIdle(input string name, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      sync();
      i++;
    end
    if (exp_q.size() != 0) begin
      failNow({name, "_timeout"}, 32'(exp_q.size()));
      exp_q.delete();
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_psel"},     32'(PSEL), 0);
    checkOutput({tag, "_penable"},  32'(PENABLE), 0);
    checkOutput({tag, "_pwrite"},   32'(PWRITE), 0);
    checkOutput({tag, "_paddr"},    32'(PADDR), 0);
    checkOutput({tag, "_pwdata"},   32'(PWDATA), 0);
    checkOutput({tag, "_tx_ready"}, 32'(tx_ready), 0);
    checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 0);
    checkOutput({tag, "_rx_data"},  32'(rx_data), 0);
    checkOutput({tag, "_err"},      32'(err_status), 0);
    checkOutput({tag, "_cfg_done"}, 32'(cfg_done), 0);
  endtask

  // Slave model drives PREADY/PRDATA at the falling edge, then the monitor samples
  // the settled bus and pops the scoreboard on each completing transfer.
  always @(negedge PCLK) begin
    xfer_t      act;
    xfer_t      e;
    logic [7:0] tmp;
    if (PSEL && !PENABLE) begin
      wait_cur = wait_n;
      wcnt     = 0;
    end
    if (PSEL && PENABLE && wcnt < wait_cur) begin
      PREADY = 1'b0;
      wcnt++;
    end else begin
      PREADY = 1'b1;
    end
    if (PSEL && PENABLE && PREADY) begin
      if (PADDR == A_ST)      PRDATA = (status_q.size() > 0) ? status_q[0] : 8'h00;
      else if (PADDR == A_RX) PRDATA = (rx_q.size() > 0) ? rx_q[0] : 8'hEE;
      else                    PRDATA = 8'h00;
    end else begin
      PRDATA = 8'hFF;
    end
    #1;
    if (PRESET) begin
      after_done = 1'b0;
      acc_cnt    = 0;
    end else begin
      if (after_done) checkOutput("no_idle_gap", 32'(PSEL && !PENABLE), 1);
      after_done = 1'b0;
      if (PSEL && !PENABLE) acc_cnt = 0;
      if (PSEL && PENABLE) acc_cnt++;
      if (PSEL && PENABLE && PREADY) begin
        checkOutput("access_cycles", 32'(acc_cnt), 32'(wait_cur + 1));
        act.wr   = PWRITE;
        act.addr = PADDR;
        act.data = PWRITE ? PWDATA : 8'h00;
        if (!(!PWRITE && PADDR == A_ST && status_q.size() == 0)) begin
          if (exp_q.size() == 0) begin
            failNow("unexpected_xfer", 32'(act));
          end else begin
            e = exp_q.pop_front();
            checkOutput("apb_xfer", 32'(act), 32'(e));
          end
          if (!PWRITE && PADDR == A_ST) tmp = status_q.pop_front();
          if (!PWRITE && PADDR == A_RX && rx_q.size() > 0) tmp = rx_q.pop_front();
        end
        after_done = 1'b1;
      end
    end
    if (rx_valid && rx_ready) begin
      if (exp_rx.size() == 0) begin
        failNow("unexpected_rx", 32'(rx_data));
      end else begin
        tmp = exp_rx.pop_front();
        checkOutput("rx_data", 32'(rx_data), 32'(tmp));
      end
    end
    if (tx_ready) begin
      checkOutput("tx_ready_cfg", 32'(cfg_done), 1);
      checkOutput("tx_ready_pulse", 32'(txr_prev), 0);
    end
    txr_prev = tx_ready;
  end

  initial begin
    int i;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    err_clr  = 1'b0;
    PRESET   = 1'b0;
    #1 PRESET = 1'b1;
    repeat (3) sync();
    checkResetOutputs("reset");

    // Configuration: CTRL1 then CTRL2, cfg_done the cycle after, then polling.
    expXfer(1'b1, A_C1, 8'h1A);
    expXfer(1'b1, A_C2, 8'h01);
    PRESET = 1'b0;
    i = 0;
    while (!(PSEL && PENABLE && PADDR == A_C2) && i < 20) begin
      sync();
      i++;
    end
    checkOutput("cfg2_access_seen", 32'(PSEL && PENABLE && PADDR == A_C2), 1);
    checkOutput("cfg_done_during_cfg2", 32'(cfg_done), 0);
    sync();
    checkOutput("cfg_done_rise", 32'(cfg_done), 1);
    checkOutput("poll_setup_addr", 32'(PADDR), 32'(A_ST));
    checkOutput("poll_setup_phase", 32'({PSEL, PENABLE, PWRITE}), 32'(3'b100));
    waitIdle("cfg", 20);

    // Both sides ready on every poll: RX first (pointer starts at TX), then alternate.
    tx_data  = 8'h11;
    tx_valid = 1'b1;
    rx_ready = 1'b1;
    applyStimulus(8'h03); expRxByte(8'h81);
    applyStimulus(8'h03); expXfer(1'b1, A_TX, 8'h11);
    applyStimulus(8'h03); expRxByte(8'h82);
    applyStimulus(8'h03); expXfer(1'b1, A_TX, 8'h11);
    waitIdle("alternate", 60);
    tx_valid = 1'b0;

    // Single TX byte.
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    applyStimulus(8'h01);
    expXfer(1'b1, A_TX, 8'hA5);
    waitIdle("tx_single", 30);
    tx_valid = 1'b0;

    // RX byte held under backpressure; RXRDY polls must not read RXDATA again.
    rx_ready = 1'b0;
    applyStimulus(8'h02); expRxByte(8'h3C);
    applyStimulus(8'h02);
    applyStimulus(8'h02);
    applyStimulus(8'h02);
    waitIdle("rx_hold", 40);
    checkOutput("rx_valid_held", 32'(rx_valid), 1);
    checkOutput("rx_data_held", 32'(rx_data), 32'h3C);
    rx_ready = 1'b1;
    sync();
    sync();
    checkOutput("rx_valid_cleared", 32'(rx_valid), 0);
    applyStimulus(8'h02); expRxByte(8'h5E);
    waitIdle("rx_resume", 30);

    // Three wait states on every transfer.
    wait_n   = 3;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    applyStimulus(8'h01); expXfer(1'b1, A_TX, 8'hC3);
    applyStimulus(8'h02); expRxByte(8'h77);
    waitIdle("wait_states", 80);
    tx_valid = 1'b0;
    wait_n   = 0;
    repeat (12) sync();

    // Sticky error bits, then a clear coinciding with new bits.
    applyStimulus(8'h14);
    waitIdle("err_set", 30);
    repeat (4) sync();
    checkOutput("err_framing_parity", 32'(err_status), 32'(3'b101));
    err_clr = 1'b1;
    applyStimulus(8'h08);
    waitIdle("err_clr", 30);
    err_clr = 1'b0;
    sync();
    checkOutput("err_clr_set_wins", 32'(err_status), 32'(3'b010));

    // Reset during the TXDATA access aborts it and restarts configuration.
    tx_data  = 8'hE7;
    tx_valid = 1'b1;
    applyStimulus(8'h01);
    i = 0;
    while (!(PSEL && PENABLE && PWRITE && PADDR == A_TX) && i < 40) begin
      sync();
      i++;
    end
    checkOutput("txwr_access_seen", 32'(PSEL && PENABLE && PWRITE && PADDR == A_TX), 1);
    PRESET = 1'b1;
    #1;
    checkResetOutputs("abort");
    tx_valid = 1'b0;
    exp_q.delete();
    sync();
    sync();
    expXfer(1'b1, A_C1, 8'h1A);
    expXfer(1'b1, A_C2, 8'h01);
    tx_data  = 8'h42;
    tx_valid = 1'b1;
    applyStimulus(8'h03); expRxByte(8'h99);
    PRESET = 1'b0;
    waitIdle("restart", 40);
    tx_valid = 1'b0;
    repeat (4) sync();
    checkOutput("rx_drained", 32'(exp_rx.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
